// File: rtl/two_phase_rx_fifo.sv
// two_phase_rx_fifo: 2-phase bundled-data receiver feeding a small FIFO
// with a valid/ready output; back-pressure by withholding the acknowledge.
module two_phase_rx_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       ack_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 req_s;
    logic                 ph;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic [WIDTH-1:0]     mem [DEPTH];

    logic pending;
    logic has_room;
    logic push;
    logic pop;

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign pending  = req_s ^ ph;
    // Room is judged on the occupancy at the start of the cycle, so a
    // same-cycle pop never lets a token into a full FIFO.
    assign has_room = count_q < CW'(DEPTH);
    assign push     = pending && has_room;
    assign pop      = (count_q != '0) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            stall <= 1'b0;
            ph    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (push) begin
                        ph    <= ~ph;
                        stall <= 1'b0;
                    end else if (pending) begin
                        state <= STALL;
                        stall <= 1'b1;
                    end
                end
                STALL: begin
                    if (push) begin
                        ph    <= ~ph;
                        state <= IDLE;
                        stall <= 1'b0;
                    end else if (!pending) begin
                        state <= IDLE;
                        stall <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign ack_out   = ph;
    assign count     = count_q;
    assign out_valid = count_q != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_two_phase_rx_fifo.sv
// tb_two_phase_rx_fifo: directed stimulus with a queue-based reference
// model compared every cycle, plus literal spot checks.
module tb_two_phase_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk;
    logic             rst_n;
    logic             req_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             stall;

    int checks;
    int failures;

    two_phase_rx_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SYNC_STAGES(S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: req history, a token queue, an acknowledge phase.
    bit             rq [$];
    bit [WIDTH-1:0] mq [$];
    bit             m_ack;
    bit             m_stall;

    always @(posedge clk) begin
        bit rs;
        bit pend;
        bit room;
        bit do_pop;
        if (!rst_n) begin
            rq.delete();
            mq.delete();
            m_ack   = 1'b0;
            m_stall = 1'b0;
        end else begin
            rq.push_back(req_in);
            rs = (rq.size() > S) ? rq[rq.size()-1-S] : 1'b0;
            if (rq.size() > S + 1) void'(rq.pop_front());
            pend    = rs != m_ack;
            room    = mq.size() < DEPTH;
            do_pop  = (mq.size() > 0) && out_ready;
            m_stall = pend && !room;
            if (do_pop) void'(mq.pop_front());
            if (pend && room) begin
                mq.push_back(data_in);
                m_ack = ~m_ack;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("ack_out", ack_out, m_ack);
        check("out_valid", out_valid, mq.size() > 0);
        check("out_data", out_data, (mq.size() > 0) ? mq[0] : 0);
        check("count", count, mq.size());
        check("stall", stall, m_stall);
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        req_in    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_data", out_data, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_out !== req_in && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_timeout", ack_out, req_in);
    endtask

    task automatic send(logic [WIDTH-1:0] d);
        @(negedge clk);
        data_in = d;
        req_in  = ~req_in;
        @(negedge clk);
        wait_ack();
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;

        // Reset and single token with exact latency
        reset_dut();
        @(negedge clk);
        data_in = 8'h5A;
        req_in  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_ack_early", ack_out, 0);
        @(negedge clk);
        check("lat_ack", ack_out, 1);
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 8'h5A);
        check("lat_count", count, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_valid", out_valid, 0);
        check("pop_count", count, 0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("empty_ready", count, 0);

        // Both phases, in-order pops
        reset_dut();
        send(8'h01);
        check("ph1_ack", ack_out, 1);
        send(8'h02);
        check("ph0_ack", ack_out, 0);
        check("ph_count", count, 2);
        check("ph_head1", out_data, 8'h01);
        pop_one();
        check("ph_head2", out_data, 8'h02);
        pop_one();
        check("ph_empty", out_valid, 0);

        // Full FIFO and stall
        reset_dut();
        for (int i = 0; i < 4; i++) send(WIDTH'(8'h10 + i));
        check("full_count", count, 4);
        @(negedge clk);
        data_in = 8'h14;
        req_in  = ~req_in;
        repeat (4) @(negedge clk);
        check("full_stall", stall, 1);
        check("full_noack", ack_out, ~req_in & 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("full_pop_cnt", count, 3);
        check("full_pop_head", out_data, 8'h11);
        check("full_pop_stall", stall, 1);
        @(negedge clk);
        check("full_cap_stall", stall, 0);
        check("full_cap_count", count, 4);
        check("full_cap_ack", ack_out, req_in);

        // Simultaneous push and pop across pointer wrap
        reset_dut();
        send(8'h20);
        send(8'h21);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            data_in = WIDTH'(8'h30 + i);
            req_in  = ~req_in;
            @(negedge clk);
            @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("pp_count", count, 2);
            check("pp_ack", ack_out, req_in);
        end
        check("pp_head", out_data, 8'h3A);
        pop_one();
        check("pp_tail", out_data, 8'h3B);
        pop_one();
        check("pp_empty", count, 0);

        // Reset with a token in flight and req_in high
        reset_dut();
        for (int i = 0; i < 4; i++) send(WIDTH'(8'h40 + i));
        pop_one();
        check("mr_count", count, 3);
        @(negedge clk);
        data_in = 8'h77;
        req_in  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mr_rst_count", count, 0);
        check("mr_rst_ack", ack_out, 0);
        wait_ack();
        check("mr_ack", ack_out, 1);
        check("mr_count1", count, 1);
        check("mr_data", out_data, 8'h77);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
